// File: rtl/sram_init_pkg.sv
// Shared types and helpers for the SRAM copy/fill engine.
package sram_init_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READ  = 3'd1,
      S_RWAIT = 3'd2,
      S_WRITE = 3'd3,
      S_WWAIT = 3'd4,
      S_FIN   = 3'd5
   } state_e;

   localparam logic MODE_COPY = 1'b0;
   localparam logic MODE_FILL = 1'b1;

   // Word width in bits for a word of (1 << data_width) bytes.
   function automatic int unsigned word_bits(input int unsigned data_width);
      return (32'd1 << data_width) * 32'd8;
   endfunction

endpackage

// File: rtl/sram_copy_engine.sv
// Block copy / block fill initiator driving the read and write ports of an SRAM.
// All outputs are registered; their next values are decoded from the next state.
module sram_copy_engine
   import sram_init_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned DATA_WIDTH = 2,
   parameter int unsigned LEN_WIDTH  = 16,
   parameter int unsigned TIMEOUT    = 15
) (
   input  logic                                  CLK,
   input  logic                                  RST,
   input  logic                                  START,
   input  logic                                  MODE,
   input  logic [ADDR_WIDTH-1:0]                 SRC_ADDR,
   input  logic [ADDR_WIDTH-1:0]                 DST_ADDR,
   input  logic [LEN_WIDTH-1:0]                  LENGTH,
   input  logic [word_bits(DATA_WIDTH)-1:0]      PATTERN,
   input  logic                                  ABORT,
   output logic                                  BUSY,
   output logic                                  DONE,
   output logic                                  ERROR,
   output logic [LEN_WIDTH-1:0]                  COUNT,
   output logic [ADDR_WIDTH-1:0]                 M_READ_ADDR,
   output logic                                  M_OE,
   input  logic [word_bits(DATA_WIDTH)-1:0]      M_DATA_OUT,
   input  logic                                  M_DATA_VALID,
   output logic [ADDR_WIDTH-1:0]                 M_WRITE_ADDR,
   output logic [word_bits(DATA_WIDTH)-1:0]      M_DATA_IN,
   output logic [(1<<DATA_WIDTH)-1:0]            M_BE,
   output logic                                  M_WE,
   input  logic                                  M_WACK
);

   localparam int unsigned WORD_W = word_bits(DATA_WIDTH);
   localparam int unsigned BE_W   = 1 << DATA_WIDTH;
   localparam int unsigned TMR_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

   state_e                 state_q, state_d;
   logic [ADDR_WIDTH-1:0]  src_q, src_d, dst_q, dst_d;
   logic [LEN_WIDTH-1:0]   len_q, len_d, count_q, count_d;
   logic                   mode_q, mode_d;
   logic [WORD_W-1:0]      pat_q, pat_d, buf_q, buf_d;
   logic [TMR_W-1:0]       timer_q, timer_d;
   logic                   abort_q, abort_d;
   logic                   busy_q, busy_d, done_q, done_d, error_q, error_d;
   logic                   oe_q, oe_d, we_q, we_d;
   logic [ADDR_WIDTH-1:0]  raddr_q, raddr_d, waddr_q, waddr_d;
   logic [WORD_W-1:0]      wdata_q, wdata_d;
   logic [BE_W-1:0]        be_q, be_d;
   logic                   abort_now;
   logic [LEN_WIDTH-1:0]   count_inc;

   assign BUSY         = busy_q;
   assign DONE         = done_q;
   assign ERROR        = error_q;
   assign COUNT        = count_q;
   assign M_READ_ADDR  = raddr_q;
   assign M_OE         = oe_q;
   assign M_WRITE_ADDR = waddr_q;
   assign M_DATA_IN    = wdata_q;
   assign M_BE         = be_q;
   assign M_WE         = we_q;

   // State, datapath and output registers.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= S_IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         len_q   <= '0;
         count_q <= '0;
         mode_q  <= MODE_COPY;
         pat_q   <= '0;
         buf_q   <= '0;
         timer_q <= '0;
         abort_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         error_q <= 1'b0;
         oe_q    <= 1'b0;
         we_q    <= 1'b0;
         raddr_q <= '0;
         waddr_q <= '0;
         wdata_q <= '0;
         be_q    <= '0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         len_q   <= len_d;
         count_q <= count_d;
         mode_q  <= mode_d;
         pat_q   <= pat_d;
         buf_q   <= buf_d;
         timer_q <= timer_d;
         abort_q <= abort_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         error_q <= error_d;
         oe_q    <= oe_d;
         we_q    <= we_d;
         raddr_q <= raddr_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
      end
   end

   // Next-state logic, then outputs decoded from the state being entered.
   always_comb begin
      state_d   = state_q;
      src_d     = src_q;
      dst_d     = dst_q;
      len_d     = len_q;
      count_d   = count_q;
      mode_d    = mode_q;
      pat_d     = pat_q;
      buf_d     = buf_q;
      timer_d   = timer_q;
      error_d   = error_q;
      raddr_d   = raddr_q;
      waddr_d   = waddr_q;
      wdata_d   = wdata_q;
      oe_d      = 1'b0;
      we_d      = 1'b0;
      be_d      = '0;
      abort_now = abort_q | (ABORT & busy_q);
      abort_d   = abort_now;
      count_inc = count_q + LEN_WIDTH'(1);

      case (state_q)
         S_IDLE: begin
            if (START) begin
               src_d   = SRC_ADDR;
               dst_d   = DST_ADDR;
               len_d   = LENGTH;
               mode_d  = MODE;
               pat_d   = PATTERN;
               count_d = '0;
               error_d = 1'b0;
               abort_d = 1'b0;
               if (LENGTH == '0)            state_d = S_FIN;
               else if (MODE == MODE_FILL)  state_d = S_WRITE;
               else                         state_d = S_READ;
            end
         end
         S_READ: begin
            timer_d = '0;
            state_d = abort_now ? S_FIN : S_RWAIT;
         end
         S_RWAIT: begin
            if (abort_now) begin
               state_d = S_FIN;
            end else if (M_DATA_VALID) begin
               buf_d   = M_DATA_OUT;
               state_d = S_WRITE;
            end else if (timer_q == TMR_LAST) begin
               error_d = 1'b1;
               state_d = S_FIN;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         S_WRITE: begin
            timer_d = '0;
            state_d = S_WWAIT;
         end
         S_WWAIT: begin
            if (M_WACK) begin
               count_d = count_inc;
               src_d   = src_q + ADDR_WIDTH'(1);
               dst_d   = dst_q + ADDR_WIDTH'(1);
               if (count_inc == len_q || abort_now) state_d = S_FIN;
               else if (mode_q == MODE_FILL)         state_d = S_WRITE;
               else                                  state_d = S_READ;
            end else if (timer_q == TMR_LAST) begin
               error_d = 1'b1;
               state_d = S_FIN;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_FIN);
      if (state_d == S_READ) begin
         oe_d    = 1'b1;
         raddr_d = src_d;
      end
      if (state_d == S_WRITE) begin
         we_d    = 1'b1;
         be_d    = '1;
         waddr_d = dst_d;
         wdata_d = (mode_d == MODE_FILL) ? pat_d : buf_d;
      end
   end

endmodule

// File: tb/tb_sram_copy_engine.sv
// Directed bench for sram_copy_engine with a behavioural registered SRAM.
module tb_sram_copy_engine;

   logic        CLK = 1'b0;
   logic        RST, START, MODE, ABORT;
   logic [15:0] SRC_ADDR, DST_ADDR, LENGTH;
   logic [31:0] PATTERN;
   logic        BUSY, DONE, ERROR;
   logic [15:0] COUNT;
   logic [15:0] M_READ_ADDR, M_WRITE_ADDR;
   logic        M_OE, M_WE, M_DATA_VALID, M_WACK;
   logic [31:0] M_DATA_OUT, M_DATA_IN;
   logic [3:0]  M_BE;

   int total = 0;
   int bad   = 0;

   always #5 CLK = ~CLK;

   sram_copy_engine dut (
      .CLK(CLK), .RST(RST), .START(START), .MODE(MODE),
      .SRC_ADDR(SRC_ADDR), .DST_ADDR(DST_ADDR), .LENGTH(LENGTH),
      .PATTERN(PATTERN), .ABORT(ABORT),
      .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR), .COUNT(COUNT),
      .M_READ_ADDR(M_READ_ADDR), .M_OE(M_OE),
      .M_DATA_OUT(M_DATA_OUT), .M_DATA_VALID(M_DATA_VALID),
      .M_WRITE_ADDR(M_WRITE_ADDR), .M_DATA_IN(M_DATA_IN),
      .M_BE(M_BE), .M_WE(M_WE), .M_WACK(M_WACK)
   );

   // SRAM model: read data one cycle after OE; WE registered, commit and WACK in the following cycle.
   logic [31:0] mem [0:65535];
   logic        we_r     = 1'b0;
   logic        dv_r     = 1'b0;
   logic [31:0] dout_r   = 32'h0;
   int          n_oe     = 0;
   int          n_writes = 0;
   int          drop_idx = -1;

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = {16'hA5A5, 16'(i)};
      mem[16'h0010] = 32'h11111111;
      mem[16'h0011] = 32'h22222222;
      mem[16'h0012] = 32'h33333333;
      mem[16'h0013] = 32'h44444444;
   end

   always @(posedge CLK) begin
      dv_r <= M_OE;
      if (M_OE) begin
         dout_r <= mem[M_READ_ADDR];
         n_oe   <= n_oe + 1;
      end
      we_r <= M_WE;
      if (M_WE) n_writes <= n_writes + 1;
      if (we_r) mem[M_WRITE_ADDR] <= M_DATA_IN;
   end

   assign M_DATA_OUT   = dout_r;
   assign M_DATA_VALID = dv_r;
   assign M_WACK       = we_r && ((n_writes - 1) != drop_idx);

   logic [31:0] src_words [4];
   int          done_c, oe_base, wr_base;

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Issue a command in the current cycle (cycle 0) and step until DONE or a cycle budget expires.
   task automatic run_cmd(input logic mode, input logic [15:0] src, input logic [15:0] dst,
                          input logic [15:0] len, input logic [31:0] pat,
                          input int abort_cyc, input int restart_cyc, output int done_cyc);
      done_cyc = -1;
      oe_base  = n_oe;
      wr_base  = n_writes;
      MODE = mode; SRC_ADDR = src; DST_ADDR = dst; LENGTH = len; PATTERN = pat;
      START = 1'b1;
      for (int c = 1; c <= 400; c++) begin
         step();
         START = (c == restart_cyc);
         if (c == restart_cyc) begin
            MODE = ~mode; DST_ADDR = 16'h0000; LENGTH = 16'h0001;
         end
         ABORT = (c == abort_cyc);
         if (DONE === 1'b1) begin
            done_cyc = c;
            break;
         end
      end
      START = 1'b0;
      ABORT = 1'b0;
   endtask

   // Checks at the DONE cycle, then one step into the first idle cycle.
   task automatic finish_cmd(input string tag, input int exp_done, input int got_done,
                             input logic [15:0] exp_count, input logic exp_err);
      chk({tag, ".done_cycle"}, 64'(got_done), 64'(exp_done));
      chk({tag, ".busy_at_done"}, 64'(BUSY), 64'd1);
      chk({tag, ".count"}, 64'(COUNT), 64'(exp_count));
      chk({tag, ".error"}, 64'(ERROR), 64'(exp_err));
      step();
      chk({tag, ".busy_after"}, 64'(BUSY), 64'd0);
      chk({tag, ".done_after"}, 64'(DONE), 64'd0);
   endtask

   initial begin
      src_words[0] = 32'h11111111; src_words[1] = 32'h22222222;
      src_words[2] = 32'h33333333; src_words[3] = 32'h44444444;
      RST = 1'b1; START = 1'b0; MODE = 1'b0; ABORT = 1'b0;
      SRC_ADDR = '0; DST_ADDR = '0; LENGTH = '0; PATTERN = '0;
      step(); step();
      chk("rst.busy", 64'(BUSY), 64'd0);
      chk("rst.done", 64'(DONE), 64'd0);
      chk("rst.error", 64'(ERROR), 64'd0);
      chk("rst.count", 64'(COUNT), 64'd0);
      chk("rst.oe_we_be", 64'({M_OE, M_WE, M_BE}), 64'd0);
      chk("rst.addrs", 64'({M_READ_ADDR, M_WRITE_ADDR}), 64'd0);
      chk("rst.wdata", 64'(M_DATA_IN), 64'd0);
      RST = 1'b0;
      step();

      // Copy of four words
      run_cmd(1'b0, 16'h0010, 16'h0100, 16'd4, 32'h0, -1, -1, done_c);
      finish_cmd("copy4", 17, done_c, 16'd4, 1'b0);
      for (int i = 0; i < 4; i++) chk($sformatf("copy4.mem%0d", i), 64'(mem[16'h0100 + 16'(i)]), 64'(src_words[i]));
      chk("copy4.writes", 64'(n_writes - wr_base), 64'd4);

      // Fill wrapping past the top of the address space
      run_cmd(1'b1, 16'h0000, 16'hFFFE, 16'd3, 32'hDEADBEEF, -1, -1, done_c);
      finish_cmd("fill3", 7, done_c, 16'd3, 1'b0);
      chk("fill3.memFFFE", 64'(mem[16'hFFFE]), 64'hDEADBEEF);
      chk("fill3.memFFFF", 64'(mem[16'hFFFF]), 64'hDEADBEEF);
      chk("fill3.mem0000", 64'(mem[16'h0000]), 64'hDEADBEEF);
      chk("fill3.mem0001", 64'(mem[16'h0001]), 64'hA5A50001);
      chk("fill3.reads", 64'(n_oe - oe_base), 64'd0);

      // Zero length, started in the first idle cycle
      run_cmd(1'b0, 16'h0010, 16'h0700, 16'd0, 32'h0, -1, -1, done_c);
      finish_cmd("len0", 1, done_c, 16'd0, 1'b0);
      chk("len0.reads", 64'(n_oe - oe_base), 64'd0);
      chk("len0.writes", 64'(n_writes - wr_base), 64'd0);

      // Abort while waiting for the second word's read data
      run_cmd(1'b0, 16'h0010, 16'h0200, 16'd8, 32'h0, 6, -1, done_c);
      finish_cmd("abort_rd", 7, done_c, 16'd1, 1'b0);
      step(); step(); step();
      chk("abort_rd.writes", 64'(n_writes - wr_base), 64'd1);
      chk("abort_rd.reads", 64'(n_oe - oe_base), 64'd2);
      chk("abort_rd.mem200", 64'(mem[16'h0200]), 64'h11111111);
      chk("abort_rd.mem201", 64'(mem[16'h0201]), 64'hA5A50201);

      // Write acknowledge dropped on word 2 -> timeout
      drop_idx = n_writes + 2;
      run_cmd(1'b0, 16'h0010, 16'h0300, 16'd4, 32'h0, -1, -1, done_c);
      drop_idx = -1;
      finish_cmd("timeout", 27, done_c, 16'd2, 1'b1);
      chk("timeout.sticky", 64'(ERROR), 64'd1);
      chk("timeout.mem301", 64'(mem[16'h0301]), 64'h22222222);

      // Abort coinciding with WACK: the word counts; new START clears ERROR
      run_cmd(1'b0, 16'h0010, 16'h0600, 16'd4, 32'h0, 4, -1, done_c);
      finish_cmd("abort_wack", 5, done_c, 16'd1, 1'b0);
      chk("abort_wack.writes", 64'(n_writes - wr_base), 64'd1);
      chk("abort_wack.mem601", 64'(mem[16'h0601]), 64'hA5A50601);

      // Reset in the middle of a copy, during WWAIT
      MODE = 1'b0; SRC_ADDR = 16'h0010; DST_ADDR = 16'h0400; LENGTH = 16'd4; START = 1'b1;
      step(); START = 1'b0;
      step(); step(); step();
      chk("midrst.busy_before", 64'(BUSY), 64'd1);
      RST = 1'b1;
      #1;
      chk("midrst.busy", 64'(BUSY), 64'd0);
      chk("midrst.count_err_done", 64'({COUNT, ERROR, DONE}), 64'd0);
      chk("midrst.oe_we_be", 64'({M_OE, M_WE, M_BE}), 64'd0);
      chk("midrst.addrs", 64'({M_READ_ADDR, M_WRITE_ADDR}), 64'd0);
      chk("midrst.wdata", 64'(M_DATA_IN), 64'd0);
      step(); step();
      RST = 1'b0;
      step();

      // Full copy after reset, with a START attempted while busy
      run_cmd(1'b0, 16'h0010, 16'h0500, 16'd4, 32'h0, -1, 3, done_c);
      finish_cmd("copy_after_rst", 17, done_c, 16'd4, 1'b0);
      for (int i = 0; i < 4; i++) chk($sformatf("copy_after_rst.mem%0d", i), 64'(mem[16'h0500 + 16'(i)]), 64'(src_words[i]));
      chk("copy_after_rst.writes", 64'(n_writes - wr_base), 64'd4);

      // Overlapping copy dst = src + 1 propagates the first word
      run_cmd(1'b0, 16'h0010, 16'h0011, 16'd3, 32'h0, -1, -1, done_c);
      finish_cmd("overlap", 13, done_c, 16'd3, 1'b0);
      chk("overlap.mem13", 64'(mem[16'h0013]), 64'h11111111);
      chk("overlap.mem12", 64'(mem[16'h0012]), 64'h11111111);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sram_copy_engine.md
# sram_copy_engine

Bus initiator that drives the read and write ports of an `sram` instance. It performs block copy (source region to destination region) or block fill (constant pattern to destination region) of word-sized data. It sits between a control register block or CPU-side command port and the SRAM. It owns the SRAM request handshakes and reports completion, word count and response timeouts.

## Interface
- `ADDR_WIDTH`, 16, SRAM word-address width
- `DATA_WIDTH`, 2, log2 of word size in bytes; word = (1<<DATA_WIDTH)*8 bits
- `LEN_WIDTH`, 16, width of transfer length/count in words
- `TIMEOUT`, 15, maximum cycles waited for `M_DATA_VALID`/`M_WACK` before error
- `CLK`  in  1  clock; one clock domain, all logic on rising edge
- `RST`  in  1  asynchronous, active-high reset
- `START`  in  1  command strobe, accepted only when idle
- `MODE`  in  1  0 = copy, 1 = fill
- `SRC_ADDR`  in  ADDR_WIDTH  first source word (copy only)
- `DST_ADDR`  in  ADDR_WIDTH  first destination word
- `LENGTH`  in  LEN_WIDTH  words to transfer
- `PATTERN`  in  word  fill value
- `ABORT`  in  1  stop after current word
- `BUSY`  out  1  high from accepted START until DONE cycle inclusive
- `DONE`  out  1  single-cycle completion pulse
- `ERROR`  out  1  sticky timeout flag, cleared by next accepted START
- `COUNT`  out  LEN_WIDTH  words written so far in current/last command
- `M_READ_ADDR`  out  ADDR_WIDTH  to SRAM READ_ADDR
- `M_OE`  out  1  to SRAM OE
- `M_DATA_OUT`  in  word  from SRAM DATA_OUT
- `M_DATA_VALID`  in  1  from SRAM DATA_VALID
- `M_WRITE_ADDR`  out  ADDR_WIDTH  to SRAM WRITE_ADDR
- `M_DATA_IN`  out  word  to SRAM DATA_IN
- `M_BE`  out  1<<DATA_WIDTH  to SRAM BE, always all-ones when `M_WE`
- `M_WE`  out  1  to SRAM WE
- `M_WACK`  in  1  from SRAM WACK

## Operation
- Reset: state IDLE. All outputs 0, including the address/data buses. Internal pointers, count and timer are 0.
- Operation is governed by a state machine with states IDLE, READ, RWAIT, WRITE, WWAIT, FIN.
- IDLE:
  - START latches SRC/DST/LENGTH/MODE/PATTERN, clears COUNT and ERROR, and raises BUSY.
  - LENGTH=0 goes to FIN.
  - MODE=0 goes to READ; MODE=1 goes to WRITE.
  - START while BUSY is ignored.
- READ: `M_OE`=1 and `M_READ_ADDR`=src pointer for one cycle, then go to RWAIT.
- RWAIT: `M_OE`=0. On `M_DATA_VALID`, capture `M_DATA_OUT` into the word buffer and go to WRITE.
- WRITE:
  - `M_WE`=1 and `M_BE`=all ones for one cycle.
  - `M_WRITE_ADDR` = dst pointer; `M_DATA_IN` = buffer (copy) or PATTERN (fill).
  - Go to WWAIT.
- WWAIT:
  - `M_WE`=0. `M_WRITE_ADDR`/`M_DATA_IN` are held unchanged, because the SRAM commits using registered WE.
  - On `M_WACK`: COUNT+1, pointers+1.
  - If COUNT+1 == LENGTH or an abort is pending, go to FIN. Otherwise go to READ (copy) or WRITE (fill).
- FIN: DONE=1 and BUSY=1 for one cycle, then go to IDLE.
- Pointers wrap modulo 2^ADDR_WIDTH without error.
- Overlapping regions are copied strictly ascending, one word at a time. Each word's write commits before the next read, so dst>src overlap propagates data. This is by design.
- ABORT:
  - ABORT is latched as "pending" any cycle BUSY=1.
  - In READ/RWAIT, a pending abort goes to FIN without writing. A late `M_DATA_VALID` is ignored.
  - In WRITE/WWAIT, the current word completes first.
- Timeout:
  - The timer resets on entry to RWAIT/WWAIT.
  - After TIMEOUT cycles without a response: ERROR=1, go to FIN. COUNT excludes the failed word.

## Timing
- START in cycle 0 (copy): READ c1, RWAIT c2 (SRAM `DATA_VALID` c2), WRITE c3, WWAIT c4 (`WACK` c4).
- Copy: DONE at cycle 4N+1 for N≥1.
- Fill: WRITE c1, WWAIT c2; DONE at cycle 2N+1.
- LENGTH=0: DONE at c1, no SRAM activity.
- COUNT updates the cycle after `M_WACK`.
- BUSY falls the cycle after DONE.
- A new START is accepted in the first cycle BUSY=0.
- Simultaneous `M_WACK` and ABORT in WWAIT: the word counts, then go to FIN.
- Simultaneous response and timer expiry: the response wins.
- RST mid-command: immediate return to IDLE, outputs 0. A write already registered by the SRAM may still commit.

## Structure
- Shared package `sram_init_pkg`:
  - state enum
  - MODE_COPY/MODE_FILL constants
  - word-width helper function (`(1<<DATA_WIDTH)*8`)
- Single module. The wait timer stays inline; no sub-module is warranted.

## Test plan
- Copy: LENGTH=4, SRC=0x0010, DST=0x0100, mem[0x10..0x13]=0x11111111..0x44444444 -> DST words match, DONE at cycle 17, COUNT=4, ERROR=0.
- Fill: LENGTH=3, DST=0xFFFE, PATTERN=0xDEADBEEF -> words 0xFFFE, 0xFFFF, 0x0000 written (wrap), DONE at cycle 7.
- LENGTH=0 -> DONE at c1, `M_OE`/`M_WE` never asserted, COUNT=0.
- ABORT in cycle 6 of a LENGTH=8 copy -> word 0 written, word 1 read discarded, COUNT=1, DONE pulse, no further writes.
- SRAM model drops `WACK` on word 2 with TIMEOUT=15 -> ERROR=1 at FIN 15 cycles into WWAIT, COUNT=2. A later START clears ERROR.
- RST asserted during WWAIT -> all outputs 0 the same cycle. START after reset runs a full copy correctly. START while BUSY is ignored.
